// File: rtl/cnna_mul_pkg.sv
// Shared constants, types and width helper for the cnna pipelined multiplier.
// The accumulate build is selected by the CNNA_MUL_ACC_EN macro.
package cnna_mul_pkg;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 6;

`ifdef CNNA_MUL_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  // Control part of a pipeline slot; the product rides next to it because its
  // width is a per-instance parameter.
  typedef struct packed {
    logic valid;
    logic last;
    logic sgn;
  } slot_meta_t;

  function automatic int dout_width(input int din0_width, input int din1_width,
                                    input int acc_width, input bit acc_en);
    return acc_en ? acc_width : din0_width + din1_width;
  endfunction

endpackage

// File: rtl/cnna_mul_pipe_stage.sv
// One enable-gated pipeline slot of the cnna multiplier (control + product).
module cnna_mul_pipe_stage
  import cnna_mul_pkg::*;
#(
  parameter int DATA_WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  slot_meta_t            d_meta,
  input  logic [DATA_WIDTH-1:0] d_data,
  output slot_meta_t            q_meta,
  output logic [DATA_WIDTH-1:0] q_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_meta <= '0;
      q_data <= '0;
    end else if (en) begin
      q_meta <= d_meta;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/cnna_mul_pipe.sv
// Pipelined, run-time-signedness multiplier with valid/ready backpressure.
// Defining CNNA_MUL_ACC_EN adds a group accumulator stage after the pipeline.
module cnna_mul_pipe
  import cnna_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 17,
  parameter int DIN1_WIDTH = 16,
  parameter int NUM_STAGE  = 3,
  parameter int ACC_WIDTH  = 48,
  localparam int DOUT_WIDTH = dout_width(DIN0_WIDTH, DIN1_WIDTH, ACC_WIDTH, ACC_EN)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  din0_signed,
  input  logic                  din1_signed,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_last
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
    $error("cnna_mul_pipe: NUM_STAGE out of range");
  end

  logic                         en;
  slot_meta_t                   meta [NUM_STAGE+1];
  logic [PROD_WIDTH-1:0]        data [NUM_STAGE+1];
  logic signed [DIN0_WIDTH:0]   a_ext;
  logic signed [DIN1_WIDTH:0]   b_ext;

  // One extra bit per operand makes a single signed multiply exact for every
  // signedness mix; only the low PROD_WIDTH bits are ever needed.
  assign a_ext   = {din0_signed & din0[DIN0_WIDTH-1], din0};
  assign b_ext   = {din1_signed & din1[DIN1_WIDTH-1], din1};
  assign data[0] = PROD_WIDTH'(a_ext) * PROD_WIDTH'(b_ext);
  assign meta[0] = '{valid: in_valid, last: in_last, sgn: din0_signed | din1_signed};

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
    cnna_mul_pipe_stage #(
      .DATA_WIDTH(PROD_WIDTH)
    ) u_stage (
      .clk   (ap_clk),
      .rst   (ap_rst),
      .en    (en),
      .d_meta(meta[i]),
      .d_data(data[i]),
      .q_meta(meta[i+1]),
      .q_data(data[i+1])
    );
  end

`ifdef CNNA_MUL_ACC_EN
  if (ACC_WIDTH < PROD_WIDTH) begin : g_bad_acc
    $error("cnna_mul_pipe: ACC_WIDTH narrower than the product");
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] acc_dout;
  logic                 acc_valid;

  assign prod_ext = meta[NUM_STAGE].sgn ? ACC_WIDTH'($signed(data[NUM_STAGE]))
                                        : ACC_WIDTH'(data[NUM_STAGE]);
  assign sum      = acc + prod_ext;

  // Only the closing beat of a group produces a result; it also restarts the sum.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc       <= '0;
      acc_dout  <= '0;
      acc_valid <= 1'b0;
    end else if (en) begin
      acc_valid <= meta[NUM_STAGE].valid && meta[NUM_STAGE].last;
      if (meta[NUM_STAGE].valid) begin
        if (meta[NUM_STAGE].last) begin
          acc_dout <= sum;
          acc      <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

  assign out_valid = acc_valid;
  assign out_last  = acc_valid;
  assign dout      = acc_dout;
`else
  logic unused_sgn;

  assign out_valid  = meta[NUM_STAGE].valid;
  assign out_last   = meta[NUM_STAGE].last;
  assign dout       = data[NUM_STAGE];
  assign unused_sgn = meta[NUM_STAGE].sgn;
`endif

endmodule

// File: tb/tb_cnna_mul_pipe.sv
// Self-checking bench for cnna_mul_pipe: constant vector table, hand sequences,
// and a randomized run against an arithmetic reference scoreboard.
module tb_cnna_mul_pipe;

  localparam int D0W  = 17;
  localparam int D1W  = 16;
  localparam int NS   = 3;
  localparam int ACCW = 48;
`ifdef CNNA_MUL_ACC_EN
  localparam int DW       = ACCW;
  localparam int EXTRA    = 1;
  localparam bit ACC_MODE = 1'b1;
`else
  localparam int DW       = D0W + D1W;
  localparam int EXTRA    = 0;
  localparam bit ACC_MODE = 1'b0;
`endif

  typedef struct {
    logic [D0W-1:0] d0;
    logic [D1W-1:0] d1;
    logic           s0;
    logic           s1;
    longint         expv;
    string          name;
  } vec_t;

  typedef struct {
    logic [DW-1:0] val;
    logic          last;
  } exp_t;

  logic ap_clk = 1'b0;
  logic ap_rst;
  logic in_valid, in_ready, in_last, din0_signed, din1_signed;
  logic out_valid, out_ready, out_last;
  logic [D0W-1:0] din0;
  logic [D1W-1:0] din1;
  logic [DW-1:0]  dout;
  logic           rdy1, ov1, ol1, rdy6, ov6, ol6;
  logic [DW-1:0]  do1, do6;

  int     n_checks = 0;
  int     n_fail   = 0;
  vec_t   vecs [8];
  exp_t   expq [$];
  longint acc_model;
  longint mon_p;
  logic   prev_stall;
  logic [DW-1:0] prev_dout;

  always #5 ap_clk = ~ap_clk;

  cnna_mul_pipe #(.DIN0_WIDTH(D0W), .DIN1_WIDTH(D1W), .NUM_STAGE(NS), .ACC_WIDTH(ACCW)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .din0_signed(din0_signed), .din1_signed(din1_signed),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .out_last(out_last));

  cnna_mul_pipe #(.DIN0_WIDTH(D0W), .DIN1_WIDTH(D1W), .NUM_STAGE(1), .ACC_WIDTH(ACCW)) u_dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(rdy1),
    .din0(din0), .din1(din1), .din0_signed(din0_signed), .din1_signed(din1_signed),
    .in_last(in_last), .out_valid(ov1), .out_ready(1'b1), .dout(do1), .out_last(ol1));

  cnna_mul_pipe #(.DIN0_WIDTH(D0W), .DIN1_WIDTH(D1W), .NUM_STAGE(6), .ACC_WIDTH(ACCW)) u_dut6 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(rdy6),
    .din0(din0), .din1(din1), .din0_signed(din0_signed), .din1_signed(din1_signed),
    .in_last(in_last), .out_valid(ov6), .out_ready(1'b1), .dout(do6), .out_last(ol6));

  // Reference arithmetic: operands as plain integers, true product, no bit tricks.
  function automatic longint opval(input logic [63:0] v, input int w, input logic sgn);
    longint r;
    r = longint'(v & ((64'd1 << w) - 64'd1));
    if (sgn && v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic longint modelProd(input logic [D0W-1:0] a, input logic [D1W-1:0] b,
                                       input logic sa, input logic sb);
    return opval(64'(a), D0W, sa) * opval(64'(b), D1W, sb);
  endfunction

  function automatic logic [DW-1:0] fit(input longint v);
    logic [63:0] t;
    t = v;
    return t[DW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [D0W-1:0] a, input logic [D1W-1:0] b,
                               input logic sa, input logic sb, input logic last);
    in_valid = 1'b1; din0 = a; din1 = b;
    din0_signed = sa; din1_signed = sb; in_last = last;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: model outputs per accepted beat, compare every valid output.
  always @(negedge ap_clk) begin
    if (ap_rst) begin
      expq.delete();
      acc_model  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_dout", 64'(dout), 64'(prev_dout));
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL sb_unexpected: got 0x%0h, expected no output", dout);
        end else begin
          checkOutput("sb_dout", 64'(dout), 64'(expq[0].val));
          checkOutput("sb_last", 64'(out_last), 64'(expq[0].last));
          if (out_ready) void'(expq.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
      if (in_valid && in_ready) begin
        mon_p = modelProd(din0, din1, din0_signed, din1_signed);
        if (!ACC_MODE) begin
          expq.push_back('{val: fit(mon_p), last: in_last});
        end else begin
          acc_model = acc_model + mon_p;
          if (in_last) begin
            expq.push_back('{val: fit(acc_model), last: 1'b1});
            acc_model = 0;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, lat1, lat3, lat6, stale, nbeat, f1, f6;
    logic [DW-1:0] got [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q6 [$];
    logic [DW-1:0] stall_dout;
    exp_t gotg [$];
    exp_t expg [$];

    vecs[0] = '{17'h1FFFF, 16'hFFFF, 1'b0, 1'b0, 64'h1_FFFD_0001, "umax_x_umax"};
    vecs[1] = '{17'h1FFFF, 16'h0005, 1'b1, 1'b0, -64'sd5, "sneg1_x_u5"};
    vecs[2] = '{17'h1FFFF, 16'hFFFF, 1'b1, 1'b1, 64'sd1, "sneg1_x_sneg1"};
    vecs[3] = '{17'h00000, 16'hFFFF, 1'b0, 1'b0, 64'sd0, "zero_x_umax"};
    vecs[4] = '{17'h10000, 16'h8000, 1'b1, 1'b1, 64'sd2147483648, "smin_x_smin"};
    vecs[5] = '{17'h10000, 16'hFFFF, 1'b0, 1'b1, -64'sd65536, "u65536_x_sneg1"};
    vecs[6] = '{17'd3, 16'd3, 1'b0, 1'b0, 64'sd9, "three_x_three"};
    vecs[7] = '{17'h1FFFF, 16'h8000, 1'b0, 1'b1, -64'sd4294934528, "umax_x_smin"};

    ap_rst = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0;
    din0_signed = 1'b0; din1_signed = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_dout", 64'(dout), 64'd0);
    checkOutput("reset_out_last", 64'(out_last), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    $display("[TB] vector table");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(vecs[k].d0, vecs[k].d1, vecs[k].s0, vecs[k].s1, 1'b1);
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge ap_clk); #1;
        lat++;
      end
      checkOutput({vecs[k].name, "_latency"}, 64'(lat), 64'(NS + EXTRA));
      checkOutput({vecs[k].name, "_dout"}, 64'(dout), 64'(fit(vecs[k].expv)));
      checkOutput({vecs[k].name, "_last"}, 64'(out_last), 64'd1);
      @(posedge ap_clk); #1;
      checkOutput({vecs[k].name, "_pulse"}, 64'(out_valid), 64'd0);
    end

    $display("[TB] backpressure stream");
    nbeat = 0;
    stall_dout = '0;
    for (int c = 0; c < 60 && got.size() < 8; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      if (nbeat < 8) begin
        in_valid = 1'b1; din0 = 17'(nbeat + 1); din1 = 16'd2;
        din0_signed = 1'b0; din1_signed = 1'b0; in_last = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge ap_clk);
      if (c >= 4 && c <= 7) checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      if (c == 4) stall_dout = dout;
      if (c > 4 && c <= 7) checkOutput("stall_dout_stable", 64'(dout), 64'(stall_dout));
      if (in_valid && in_ready) nbeat++;
      if (out_valid && out_ready) got.push_back(dout);
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checkOutput("stream_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      checkOutput("stream_value", (i < got.size()) ? 64'(got[i]) : 64'hDEAD, 64'(2 * (i + 1)));
    repeat (10) @(posedge ap_clk);
    #1;

    $display("[TB] reset mid-stream");
    for (int k = 0; k < 3; k++) applyStimulus(17'(k + 5), 16'd7, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_pre_out_valid", 64'(out_valid), ACC_MODE ? 64'd0 : 64'd1);
    ap_rst = 1'b1;
    #1;
    checkOutput("rst_out_valid_async", 64'(out_valid), 64'd0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    stale = 0;
    repeat (12) begin
      @(negedge ap_clk);
      if (out_valid) stale++;
    end
    @(posedge ap_clk); #1;
    checkOutput("rst_no_stale", 64'(stale), 64'd0);
    applyStimulus(17'd3, 16'd3, 1'b0, 1'b0, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge ap_clk); #1;
      lat++;
    end
    checkOutput("rst_after_latency", 64'(lat), 64'(NS + EXTRA));
    checkOutput("rst_after_dout", 64'(dout), 64'd9);
    repeat (4) @(posedge ap_clk);
    #1;

    $display("[TB] stage sweep");
    applyStimulus(17'd4, 16'd4, 1'b0, 1'b0, 1'b1);
    lat1 = 0; lat3 = 0; lat6 = 0;
    for (int c = 1; c <= 15; c++) begin
      if (ov1 && lat1 == 0) lat1 = c;
      if (out_valid && lat3 == 0) lat3 = c;
      if (ov6 && lat6 == 0) lat6 = c;
      @(posedge ap_clk); #1;
    end
    checkOutput("sweep_latency_1", 64'(lat1), 64'(1 + EXTRA));
    checkOutput("sweep_latency_3", 64'(lat3), 64'(3 + EXTRA));
    checkOutput("sweep_latency_6", 64'(lat6), 64'(6 + EXTRA));
    f1 = -1; f6 = -1;
    for (int c = 0; c < 30; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; din0 = 17'(c + 1); din1 = 16'd3;
        din0_signed = 1'b0; din1_signed = 1'b0; in_last = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge ap_clk); #1;
      if (ov1) begin
        if (f1 < 0) f1 = c;
        q1.push_back(do1);
      end
      if (ov6) begin
        if (f6 < 0) f6 = c;
        q6.push_back(do6);
      end
    end
    checkOutput("tput1_count", 64'(q1.size()), 64'd8);
    checkOutput("tput6_count", 64'(q6.size()), 64'd8);
    checkOutput("tput6_gap", 64'(f6 - f1), 64'd5);
    for (int i = 0; i < 8; i++) begin
      checkOutput("tput1_value", (i < q1.size()) ? 64'(q1[i]) : 64'hDEAD, 64'(3 * (i + 1)));
      checkOutput("tput6_value", (i < q6.size()) ? 64'(q6[i]) : 64'hDEAD, 64'(3 * (i + 1)));
    end

    $display("[TB] group sequence");
`ifdef CNNA_MUL_ACC_EN
    expg.push_back('{val: fit(64'sd19), last: 1'b1});
    expg.push_back('{val: fit(64'sd100), last: 1'b1});
`else
    expg.push_back('{val: fit(64'sd6), last: 1'b0});
    expg.push_back('{val: fit(64'sd20), last: 1'b0});
    expg.push_back('{val: fit(-64'sd7), last: 1'b1});
    expg.push_back('{val: fit(64'sd100), last: 1'b1});
`endif
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 4);
      case (c)
        0: begin din0 = 17'd2;     din1 = 16'd3;  din0_signed = 1'b0; din1_signed = 1'b0; in_last = 1'b0; end
        1: begin din0 = 17'd4;     din1 = 16'd5;  din0_signed = 1'b0; din1_signed = 1'b0; in_last = 1'b0; end
        2: begin din0 = 17'h1FFFF; din1 = 16'd7;  din0_signed = 1'b1; din1_signed = 1'b0; in_last = 1'b1; end
        3: begin din0 = 17'd10;    din1 = 16'd10; din0_signed = 1'b0; din1_signed = 1'b0; in_last = 1'b1; end
        default: ;
      endcase
      @(posedge ap_clk); #1;
      if (out_valid) gotg.push_back('{val: dout, last: out_last});
    end
    checkOutput("group_count", 64'(gotg.size()), 64'(expg.size()));
    for (int i = 0; i < expg.size(); i++) begin
      checkOutput("group_dout", (i < gotg.size()) ? 64'(gotg[i].val) : 64'hDEAD, 64'(expg[i].val));
      checkOutput("group_last", (i < gotg.size()) ? 64'(gotg[i].last) : 64'hDEAD, 64'(expg[i].last));
    end

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      din0        = D0W'($urandom);
      din1        = D1W'($urandom);
      din0_signed = 1'($urandom);
      din1_signed = 1'($urandom);
      in_last     = ($urandom_range(0, 2) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      @(posedge ap_clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 50 && expq.size() != 0; c++) @(posedge ap_clk);
    #1;
    checkOutput("drain_empty", 64'(expq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
